// File: rtl/program_loader_pkg.sv
// Shared constants and state encoding for the boot-time UART program loader.
package program_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hAA;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        ACK_REQ,
        ACK_WAIT,
        DONE,
        ERROR
    } loader_state_t;

endpackage

// File: rtl/program_loader_byte_assembler.sv
// Big-endian 4-byte assembler; word/word_valid are presented on the 4th byte itself.
module program_loader_byte_assembler (
    input  logic        clk,
    input  logic        rstn,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [23:0] sr;
    logic [1:0]  cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sr  <= '0;
            cnt <= '0;
        end else if (clr) begin
            sr  <= '0;
            cnt <= '0;
        end else if (byte_valid) begin
            sr  <= {sr[15:0], byte_in};
            cnt <= cnt + 2'd1;
        end
    end

    assign word       = {sr, byte_in};
    assign word_valid = byte_valid && (cnt == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Boot loader: sync byte, 32-bit word count, N instructions into imem, then an ack byte.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int INST_SIZE = 15
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    input  logic                 rx_ferr,
    output logic [7:0]           tx_data,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic                 inst_we,
    output logic [INST_SIZE-1:0] inst_addr,
    output logic [31:0]          inst_wdata,
    output logic                 sync_received,
    output logic                 load_done,
    output logic                 ack_sent,
    output logic                 err
);

    localparam logic [32:0] DEPTH = 33'd1 << INST_SIZE;

    loader_state_t      state, state_next;
    logic [31:0]        word;
    logic               word_valid;
    logic               asm_valid;
    logic               asm_clr;
    logic               rx_bad;
    logic               len_oversize;
    logic [INST_SIZE:0] n_words;
    logic [INST_SIZE:0] word_cnt;
    logic [1:0]         wait_cnt;

    assign rx_bad       = rx_valid && rx_ferr;
    assign asm_valid    = rx_valid && !rx_ferr && (state == LEN || state == DATA);
    assign asm_clr      = (state_next != state);
    assign len_oversize = ({1'b0, word} > DEPTH);

    program_loader_byte_assembler u_byte_assembler (
        .clk        (clk),
        .rstn       (rstn),
        .clr        (asm_clr),
        .byte_valid (asm_valid),
        .byte_in    (rx_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= IDLE;
            n_words       <= '0;
            word_cnt      <= '0;
            wait_cnt      <= '0;
            inst_we       <= 1'b0;
            inst_addr     <= '0;
            inst_wdata    <= '0;
            sync_received <= 1'b0;
            load_done     <= 1'b0;
            ack_sent      <= 1'b0;
            err           <= 1'b0;
        end else begin
            state   <= state_next;
            inst_we <= 1'b0;

            // Counts cycles spent in ACK_WAIT so tx_busy has time to rise after tx_start.
            if (state != ACK_WAIT)
                wait_cnt <= '0;
            else if (wait_cnt != 2'd3)
                wait_cnt <= wait_cnt + 2'd1;

            if (state == LEN && word_valid) begin
                n_words  <= word[INST_SIZE:0];
                word_cnt <= '0;
            end

            if (state == DATA && word_valid) begin
                inst_we    <= 1'b1;
                inst_addr  <= word_cnt[INST_SIZE-1:0];
                inst_wdata <= word;
                word_cnt   <= word_cnt + 1'b1;
            end

            if (state == IDLE && state_next == LEN)
                sync_received <= 1'b1;
            if ((state == LEN || state == DATA) && state_next == ACK_REQ)
                load_done <= 1'b1;
            if (state == ACK_WAIT && state_next == DONE)
                ack_sent <= 1'b1;
            if (state != ERROR && state_next == ERROR)
                err <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:
                if (rx_valid && rx_data == SYNC_BYTE)
                    state_next = LEN;
            LEN:
                if (rx_bad)
                    state_next = ERROR;
                else if (word_valid) begin
                    if (word == 32'd0)
                        state_next = ACK_REQ;
                    else if (len_oversize)
                        state_next = ERROR;
                    else
                        state_next = DATA;
                end
            DATA:
                if (rx_bad)
                    state_next = ERROR;
                else if (inst_we && word_cnt == n_words)
                    state_next = ACK_REQ;
            ACK_REQ:
                if (!tx_busy)
                    state_next = ACK_WAIT;
            ACK_WAIT:
                if (wait_cnt != 2'd0 && !tx_busy)
                    state_next = DONE;
            default:
                state_next = state;
        endcase
    end

    always_comb begin
        tx_start = 1'b0;
        tx_data  = 8'h00;
        if (state == ACK_REQ) begin
            tx_data  = SYNC_BYTE;
            tx_start = !tx_busy;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: vector table, corner sequences, randomized streams vs a parser model.
module tb_program_loader;
    import program_loader_pkg::*;

    localparam int IS    = 4;
    localparam int DEPTH = 16;
    localparam int GAP   = 2;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ferr = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_busy;
    logic          inst_we;
    logic [IS-1:0] inst_addr;
    logic [31:0]   inst_wdata;
    logic          sync_received, load_done, ack_sent, err;

    always #5 clk = ~clk;

    program_loader #(.INST_SIZE(IS)) dut (
        .clk(clk), .rstn(rstn),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ferr(rx_ferr),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .inst_we(inst_we), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .sync_received(sync_received), .load_done(load_done),
        .ack_sent(ack_sent), .err(err)
    );

    // uart_tx stand-in: busy rises the cycle after tx_start and stays up for 6 cycles.
    logic force_busy = 1'b0;
    int   busy_cnt = 0;
    always @(posedge clk) begin
        if (tx_start) busy_cnt <= 6;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = force_busy || (busy_cnt != 0);

    int          wa_q[$];
    logic [31:0] wd_q[$];
    int          n_txs = 0;
    logic [7:0]  last_txd = 8'h00;
    always @(negedge clk) begin
        if (inst_we) begin
            wa_q.push_back(int'(inst_addr));
            wd_q.push_back(inst_wdata);
        end
        if (tx_start) begin
            n_txs++;
            last_txd = tx_data;
        end
    end

    int total = 0;
    int bad = 0;
    int base_w, base_tx;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] wd_at(input int i);
        return (base_w + i < wd_q.size()) ? wd_q[base_w + i] : 32'hxxxxxxxx;
    endfunction

    function automatic logic [31:0] wa_at(input int i);
        return (base_w + i < wa_q.size()) ? 32'(wa_q[base_w + i]) : 32'hxxxxxxxx;
    endfunction

    task automatic do_reset();
        rstn = 1'b0;
        rx_valid = 1'b0;
        rx_ferr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic mark();
        base_w  = wa_q.size();
        base_tx = n_txs;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic f);
        rx_data = b; rx_valid = 1'b1; rx_ferr = f;
        @(posedge clk);
        #1;
        rx_valid = 1'b0; rx_ferr = 1'b0;
        repeat (GAP) @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], 1'b0);
    endtask

    // Reference: parse the byte stream by the protocol rules directly.
    logic [7:0]  sb[$];
    bit          sf[$];
    logic [31:0] ew[$];
    logic        e_sync, e_done, e_err;

    task automatic model();
        int i;
        logic [31:0] n, w;
        ew.delete();
        e_sync = 0; e_done = 0; e_err = 0;
        i = 0;
        while (i < sb.size() && sb[i] != SYNC_BYTE) i++;
        if (i >= sb.size()) return;
        e_sync = 1;
        i++;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            if (i >= sb.size()) return;
            if (sf[i]) begin e_err = 1; return; end
            n = {n[23:0], sb[i]};
            i++;
        end
        if (n > DEPTH) begin e_err = 1; return; end
        for (int wi = 0; wi < int'(n); wi++) begin
            w = 0;
            for (int k = 0; k < 4; k++) begin
                if (i >= sb.size()) return;
                if (sf[i]) begin e_err = 1; return; end
                w = {w[23:0], sb[i]};
                i++;
            end
            ew.push_back(w);
        end
        e_done = 1;
    endtask

    task automatic run_stream(input string tag);
        model();
        do_reset();
        mark();
        for (int i = 0; i < sb.size(); i++) send_byte(sb[i], sf[i]);
        repeat (30) @(posedge clk);
        #1;
        check({tag, " nwrites"}, 32'(wa_q.size() - base_w), 32'(ew.size()));
        for (int i = 0; i < ew.size(); i++) begin
            check({tag, " addr"}, wa_at(i), 32'(i));
            check({tag, " data"}, wd_at(i), ew[i]);
        end
        check({tag, " flags"}, {28'd0, sync_received, load_done, ack_sent, err},
              {28'd0, e_sync, e_done, e_done, e_err});
        check({tag, " tx_starts"}, 32'(n_txs - base_tx), 32'(e_done));
        if (e_done) check({tag, " tx_data"}, 32'(last_txd), 32'(SYNC_BYTE));
    endtask

    typedef struct {
        int           len;
        logic [127:0] bytes;
        int           ferr_idx;
        int           exp_nw;
        logic [31:0]  exp_w0;
        logic [31:0]  exp_w1;
        logic [3:0]   exp_flags;   // {sync, load_done, ack_sent, err}
        int           exp_tx;
    } vec_t;

    vec_t vt[5];

    initial begin
        vt[0] = '{13, {8'hAA, 32'd2, 32'h12345678, 32'hDEADBEEF, 24'h0}, -1, 2,
                  32'h12345678, 32'hDEADBEEF, 4'b1110, 1};
        vt[1] = '{11, {8'h55, 8'h00, 8'hAA, 32'd1, 32'h0000002A, 40'h0}, -1, 1,
                  32'h0000002A, 32'h0, 4'b1110, 1};
        vt[2] = '{5, {8'hAA, 32'd0, 88'h0}, -1, 0, 32'h0, 32'h0, 4'b1110, 1};
        vt[3] = '{9, {8'hAA, 32'h11, 32'h01020304, 56'h0}, -1, 0, 32'h0, 32'h0, 4'b1001, 0};
        vt[4] = '{9, {8'hAA, 32'd1, 32'h12345678, 56'h0}, 6, 0, 32'h0, 32'h0, 4'b1001, 0};

        do_reset();
        check("reset ctl", {14'd0, tx_data, tx_start, inst_we, inst_addr,
                            sync_received, load_done, ack_sent, err}, 32'd0);
        check("reset wdata", inst_wdata, 32'd0);

        for (int v = 0; v < 5; v++) begin
            do_reset();
            mark();
            for (int i = 0; i < vt[v].len; i++) begin
                logic [127:0] bv;
                bv = vt[v].bytes;
                send_byte(bv[127 - 8*i -: 8], i == vt[v].ferr_idx);
            end
            repeat (30) @(posedge clk);
            #1;
            check($sformatf("vec%0d nwrites", v), 32'(wa_q.size() - base_w), 32'(vt[v].exp_nw));
            if (vt[v].exp_nw > 0) begin
                check($sformatf("vec%0d addr0", v), wa_at(0), 32'd0);
                check($sformatf("vec%0d w0", v), wd_at(0), vt[v].exp_w0);
            end
            if (vt[v].exp_nw > 1) begin
                check($sformatf("vec%0d addr1", v), wa_at(1), 32'd1);
                check($sformatf("vec%0d w1", v), wd_at(1), vt[v].exp_w1);
            end
            check($sformatf("vec%0d flags", v), {28'd0, sync_received, load_done, ack_sent, err},
                  {28'd0, vt[v].exp_flags});
            check($sformatf("vec%0d tx_starts", v), 32'(n_txs - base_tx), 32'(vt[v].exp_tx));
            if (vt[v].exp_tx > 0) check($sformatf("vec%0d tx_data", v), 32'(last_txd), 32'hAA);
        end

        // Sync only after the AA byte.
        do_reset();
        send_byte(8'h55, 1'b0);
        send_byte(8'h00, 1'b0);
        check("garbage no sync", 32'(sync_received), 32'd0);
        send_byte(8'hAA, 1'b0);
        check("sync after AA", 32'(sync_received), 32'd1);

        // Last data byte -> inst_we one cycle later, load_done two cycles later.
        do_reset();
        send_byte(8'hAA, 1'b0);
        send_word(32'd1);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h56, 1'b0);
        rx_data = 8'h78; rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        check("lat we+1", {30'd0, inst_we, load_done}, 32'b10);
        check("lat wdata", inst_wdata, 32'h12345678);
        @(posedge clk);
        #1;
        check("lat done+2", {30'd0, inst_we, load_done}, 32'b01);

        // Ack held off by tx_busy.
        do_reset();
        force_busy = 1'b1;
        mark();
        send_byte(8'hAA, 1'b0);
        send_word(32'd0);
        repeat (100) @(posedge clk);
        #1;
        check("busy no tx", 32'(n_txs - base_tx), 32'd0);
        check("busy no ack", {30'd0, load_done, ack_sent}, 32'b10);
        force_busy = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("busy tx after drop", 32'(n_txs - base_tx), 32'd1);
        check("busy ack", 32'(ack_sent), 32'd1);

        // Reset in the middle of DATA, then a fresh load restarts at address 0.
        do_reset();
        send_byte(8'hAA, 1'b0);
        send_word(32'd2);
        send_word(32'h11223344);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        check("midreset outs", {14'd0, tx_data, tx_start, inst_we, inst_addr,
                                sync_received, load_done, ack_sent, err}, 32'd0);
        rstn = 1'b1;
        mark();
        send_byte(8'hAA, 1'b0);
        send_word(32'd1);
        send_word(32'hCAFEBABE);
        repeat (30) @(posedge clk);
        #1;
        check("restart nwrites", 32'(wa_q.size() - base_w), 32'd1);
        check("restart addr", wa_at(0), 32'd0);
        check("restart data", wd_at(0), 32'hCAFEBABE);

        // Full-depth load and one-past-depth length.
        sb.delete(); sf.delete();
        sb.push_back(8'hAA); sf.push_back(0);
        for (int k = 3; k >= 0; k--) begin sb.push_back(8'(DEPTH >> (8*k))); sf.push_back(0); end
        for (int i = 0; i < DEPTH * 4; i++) begin sb.push_back(8'(i * 7 + 1)); sf.push_back(0); end
        run_stream("fulldepth");
        sb[4] = 8'(DEPTH + 1);
        run_stream("depth+1");

        for (int t = 0; t < 25; t++) begin
            int np, sel, nd;
            logic [31:0] n;
            logic [7:0] b;
            sb.delete(); sf.delete();
            np = $urandom_range(0, 2);
            for (int i = 0; i < np; i++) begin
                b = 8'($urandom_range(0, 255));
                if (b == SYNC_BYTE) b = 8'h55;
                sb.push_back(b); sf.push_back(0);
            end
            sb.push_back(SYNC_BYTE); sf.push_back(0);
            sel = $urandom_range(0, 7);
            case (sel)
                0: n = 0;
                1: n = DEPTH;
                2: n = $urandom_range(DEPTH + 1, 1000);
                3: n = $urandom | 32'h80000000;
                default: n = $urandom_range(1, 6);
            endcase
            for (int k = 3; k >= 0; k--) begin sb.push_back(n[8*k +: 8]); sf.push_back(0); end
            nd = (n > DEPTH) ? 1 : int'(n);
            for (int i = 0; i < nd * 4; i++) begin sb.push_back(8'($urandom)); sf.push_back(0); end
            if ($urandom_range(0, 3) == 0) sf[$urandom_range(np + 1, sb.size() - 1)] = 1;
            run_stream($sformatf("rand%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
